// File: rtl/alu_ctrl_pkg.sv
// Shared definitions for the ALU load sequencer: step/state encodings,
// load bus bit positions and the state-to-strobe mapping.
package alu_ctrl_pkg;

  typedef logic [1:0] state_t;

  localparam state_t WAIT_X  = 2'd0;
  localparam state_t WAIT_Y  = 2'd1;
  localparam state_t WAIT_OP = 2'd2;
  localparam state_t SHOW    = 2'd3;

  localparam int LOAD_X  = 0;
  localparam int LOAD_Y  = 1;
  localparam int LOAD_OP = 2;

  localparam logic [1:0] STEP_SHOW = SHOW;

  // Capture strobe issued when enter is accepted in the given state; SHOW captures nothing.
  function automatic logic [2:0] load_strobe(input state_t s);
    logic [2:0] strobe;
    strobe = 3'b000;
    case (s)
      WAIT_X:  strobe[LOAD_X]  = 1'b1;
      WAIT_Y:  strobe[LOAD_Y]  = 1'b1;
      WAIT_OP: strobe[LOAD_OP] = 1'b1;
      default: strobe = 3'b000;
    endcase
    return strobe;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Button conditioner: 2-FF synchronizer, stability counter and a registered
// one-cycle pulse on each accepted press (release gives no pulse).
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = 20
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic press
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic             sync1_r;
  logic             sync2_r;
  logic             stable_r;
  logic             stable_d_r;
  logic             press_r;
  logic [CNT_W-1:0] cnt_r;

  // Synchronize, qualify the level over DEBOUNCE_CYCLES and register its rising edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_r    <= 1'b0;
      sync2_r    <= 1'b0;
      stable_r   <= 1'b0;
      stable_d_r <= 1'b0;
      press_r    <= 1'b0;
      cnt_r      <= '0;
    end else begin
      sync1_r    <= btn;
      sync2_r    <= sync1_r;
      stable_d_r <= stable_r;
      press_r    <= stable_r & ~stable_d_r;
      // A level must differ from the accepted one for a full window before it is taken.
      if (sync2_r == stable_r) begin
        cnt_r <= '0;
      end else if (cnt_r == CNT_LAST) begin
        stable_r <= sync2_r;
        cnt_r    <= '0;
      end else begin
        cnt_r <= cnt_r + CNT_ONE;
      end
    end
  end

  assign press = press_r;

endmodule

// File: rtl/alu_load_sequencer.sv
// Steps the ALU through x, y and opcode capture on debounced enter presses,
// emitting a one-cycle one-hot load strobe per capture; clear restarts at x.
module alu_load_sequencer
  import alu_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = 20
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_enter,
  input  logic       btn_clear,
  output logic [2:0] load,
  output logic [1:0] step,
  output logic       result_valid
);

  logic       enter_press_s;
  logic       clear_press_s;
  state_t     state_r;
  state_t     next_state_s;
  logic [2:0] load_r;
  logic [2:0] next_load_s;
  logic       result_valid_r;

  btn_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .CNT_W           (CNT_W)
  ) u_enter (
    .clk   (clk),
    .reset (reset),
    .btn   (btn_enter),
    .press (enter_press_s)
  );

  btn_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .CNT_W           (CNT_W)
  ) u_clear (
    .clk   (clk),
    .reset (reset),
    .btn   (btn_clear),
    .press (clear_press_s)
  );

  // Next-state and strobe selection; clear overrides a coincident enter.
  always_comb begin
    next_state_s = state_r;
    next_load_s  = 3'b000;
    if (clear_press_s) begin
      next_state_s = WAIT_X;
    end else if (enter_press_s) begin
      next_load_s = load_strobe(state_r);
      case (state_r)
        WAIT_X:  next_state_s = WAIT_Y;
        WAIT_Y:  next_state_s = WAIT_OP;
        WAIT_OP: next_state_s = SHOW;
        SHOW:    next_state_s = WAIT_X;
        default: next_state_s = WAIT_X;
      endcase
    end else begin
      next_state_s = state_r;
    end
  end

  // State, strobe and valid flag are all registered so the outputs are glitch-free.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r        <= WAIT_X;
      load_r         <= 3'b000;
      result_valid_r <= 1'b0;
    end else begin
      state_r        <= next_state_s;
      load_r         <= next_load_s;
      result_valid_r <= (next_state_s == STEP_SHOW);
    end
  end

  assign load         = load_r;
  assign step         = state_r;
  assign result_valid = result_valid_r;

endmodule

// File: tb/tb_alu_load_sequencer.sv
// Self-checking bench: a behavioural model predicts every output cycle into a
// scoreboard queue, a negedge monitor compares; directed scenarios add counts.
module tb_alu_load_sequencer;

  localparam int DC = 4;

  logic       clk;
  logic       reset;
  logic       btn_enter;
  logic       btn_clear;
  logic [2:0] load;
  logic [1:0] step;
  logic       result_valid;

  typedef struct packed {
    logic [2:0] load;
    logic [1:0] step;
    logic       rv;
  } exp_t;

  exp_t       exp_q[$];
  int         checks = 0;
  int         failures = 0;
  int         cyc = 0;
  int         strobe_cnt = 0;
  int         strobe_cyc = 0;
  logic [2:0] strobe_vals[$];

  // model state (index 0 = enter, 1 = clear)
  int m_dly0[2], m_dly1[2], m_stab[2], m_run[2], m_ra[2], m_rb[2];
  int m_step;

  alu_load_sequencer #(.DEBOUNCE_CYCLES(DC), .CNT_W(3)) dut (
    .clk          (clk),
    .reset        (reset),
    .btn_enter    (btn_enter),
    .btn_clear    (btn_clear),
    .load         (load),
    .step         (step),
    .result_valid (result_valid)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: a press is accepted once the synchronized level has held a
  // new value for DC cycles; it reaches the FSM two edges later.
  always @(posedge clk) begin
    int   raw[2];
    int   act[2];
    int   seen, rise, ld;
    exp_t e;
    cyc++;
    raw[0] = int'(btn_enter);
    raw[1] = int'(btn_clear);
    ld = 0;
    if (reset) begin
      for (int b = 0; b < 2; b++) begin
        m_dly0[b] = 0; m_dly1[b] = 0; m_stab[b] = 0;
        m_run[b] = 0; m_ra[b] = 0; m_rb[b] = 0;
      end
      m_step = 0;
    end else begin
      for (int b = 0; b < 2; b++) begin
        seen = m_dly1[b];
        m_dly1[b] = m_dly0[b];
        m_dly0[b] = raw[b];
        rise = 0;
        if (seen != m_stab[b]) begin
          m_run[b]++;
          if (m_run[b] == DC) begin
            m_stab[b] = seen;
            m_run[b] = 0;
            rise = seen;
          end
        end else begin
          m_run[b] = 0;
        end
        act[b] = m_rb[b];
        m_rb[b] = m_ra[b];
        m_ra[b] = rise;
      end
      if (act[1] != 0) begin
        m_step = 0;
      end else if (act[0] != 0) begin
        if (m_step < 3) ld = 1 << m_step;
        m_step = (m_step + 1) % 4;
      end
    end
    e.load = 3'(ld);
    e.step = 2'(m_step);
    e.rv   = (m_step == 3);
    exp_q.push_back(e);
  end

  // Monitor: compare every presented output cycle against the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check_int("load", int'(load), int'(e.load));
      check_int("step", int'(step), int'(e.step));
      check_int("result_valid", int'(result_valid), int'(e.rv));
      if (load != 3'b000) begin
        strobe_cnt++;
        strobe_cyc = cyc;
        strobe_vals.push_back(load);
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    reset = 1'b1; btn_enter = 1'b0; btn_clear = 1'b0;
    idle(n);
    reset = 1'b0;
  endtask

  task automatic clear_log();
    strobe_cnt = 0;
    strobe_vals.delete();
  endtask

  task automatic press_enter(input int hi, input int lo);
    btn_enter = 1'b1;
    idle(hi);
    btn_enter = 1'b0;
    idle(lo);
  endtask

  initial begin
    int pe;
    reset = 1'b1; btn_enter = 1'b0; btn_clear = 1'b0;

    // reset held 3 cycles, then idle
    idle(3);
    reset = 1'b0;
    clear_log();
    idle(20);
    check_int("idle_strobes", strobe_cnt, 0);
    check_int("idle_step", int'(step), 0);

    // held enter: one strobe DC+3 edges after first sample
    idle(2);
    clear_log();
    pe = cyc + 1;
    btn_enter = 1'b1;
    idle(30);
    btn_enter = 1'b0;
    idle(20);
    check_int("held_strobes", strobe_cnt, 1);
    check_int("held_latency", strobe_cyc - pe, DC + 3);
    if (strobe_vals.size() > 0) check_int("held_value", int'(strobe_vals[0]), 1);
    check_int("held_step", int'(step), 1);

    // four clean presses walk x, y, op, show and back
    do_reset(2);
    clear_log();
    for (int i = 0; i < 4; i++) begin
      press_enter(10, 10);
      check_int("walk_step", int'(step), (i + 1) % 4);
    end
    check_int("walk_strobes", strobe_cnt, 3);
    for (int i = 0; i < 3 && i < strobe_vals.size(); i++)
      check_int("walk_value", int'(strobe_vals[i]), 1 << i);

    // bounce faster than the debounce window
    do_reset(2);
    clear_log();
    for (int i = 0; i < 10; i++) begin
      btn_enter = ~btn_enter;
      idle(2);
    end
    btn_enter = 1'b0;
    idle(15);
    check_int("bounce_strobes", strobe_cnt, 0);
    check_int("bounce_step", int'(step), 0);

    // enter and clear together in WAIT_OP: clear wins
    do_reset(2);
    press_enter(10, 10);
    press_enter(10, 10);
    check_int("tie_pre_step", int'(step), 2);
    clear_log();
    btn_enter = 1'b1; btn_clear = 1'b1;
    idle(10);
    btn_enter = 1'b0; btn_clear = 1'b0;
    idle(15);
    check_int("tie_strobes", strobe_cnt, 0);
    check_int("tie_step", int'(step), 0);

    // reset one cycle before the y strobe discards it
    do_reset(2);
    press_enter(10, 10);
    clear_log();
    btn_enter = 1'b1;
    idle(6);
    reset = 1'b1; btn_enter = 1'b0;
    idle(1);
    reset = 1'b0;
    idle(15);
    check_int("rst_strobes", strobe_cnt, 0);
    check_int("rst_step", int'(step), 0);
    press_enter(10, 10);
    check_int("rst_next_strobes", strobe_cnt, 1);
    if (strobe_vals.size() > 0) check_int("rst_next_value", int'(strobe_vals[0]), 1);

    // randomized button noise with occasional resets, scoreboard only
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 7) == 0) btn_enter = ~btn_enter;
      if ($urandom_range(0, 19) == 0) btn_clear = ~btn_clear;
      reset = ($urandom_range(0, 299) == 0);
    end
    reset = 1'b0; btn_enter = 1'b0; btn_clear = 1'b0;
    idle(20);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
